// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Holds the displayed value in an "active" register that only reloads at frame
// boundaries from a shadow register, so a write never tears a frame. Each digit slot
// starts with a dead-time window with every digit off, and leading zero digits can be
// blanked. All outputs are registered and are computed from next-state values, so they
// line up with the new counter and index without an extra cycle of lag.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int CLK_DIV  = 50000,
    parameter int DEAD     = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  data_we,
    output logic [3:0]            hex_out,
    output logic                  blank,
    output logic [DIGITS-1:0]     dig_en_n,
    output logic                  frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam bit LZ_EN = (BLANK_LZ != 0);

    // Architectural state
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [4*DIGITS-1:0]   shadow_reg, shadow_next;
    logic [4*DIGITS-1:0]   active_reg, active_next;
    logic                  pending_reg, pending_next;

    // Decoded strobes and next-state output values
    logic                  tick;
    logic                  fb;
    logic                  dead_next;
    logic [3:0]            nib_next [DIGITS];
    logic [DIGITS-1:0]     lz_next;
    logic [DIGITS-1:0]     en_next;
    logic                  blank_next;

    // Prescaler, digit index and shadow/active handover for the coming cycle
    always_comb begin
        tick        = (cnt_reg == CNT_MAX);
        fb          = tick && (idx_reg == IDX_MAX);
        cnt_next    = tick ? '0 : cnt_reg + CW'(1);
        idx_next    = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + IW'(1);
        end
        shadow_next  = data_we ? data_in : shadow_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        if (fb) begin
            // A write landing exactly on the boundary goes straight to the display.
            if (data_we) begin
                active_next = data_in;
            end else if (pending_reg) begin
                active_next = shadow_reg;
            end
            pending_next = 1'b0;
        end else if (data_we) begin
            pending_next = 1'b1;
        end
    end

    // Dead-time window at the start of every slot; a zero-length window never applies
    generate
        if (DEAD == 0) begin : g_no_dead
            assign dead_next = 1'b0;
        end else begin : g_dead
            assign dead_next = (cnt_next < CW'(DEAD));
        end
    endgenerate

    // Per-digit nibble, "this digit and everything above it is zero" flag, and enable
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_next[gi] = active_next[4*gi +: 4];
            assign lz_next[gi]  = ~|active_next[4*DIGITS-1 : 4*gi];
            assign en_next[gi]  = dead_next | (idx_next != IW'(gi));
        end
    endgenerate

    // Digit 0 is excluded from leading-zero blanking so a zero value still shows "0"
    assign blank_next = dead_next | (LZ_EN && (idx_next != '0) && lz_next[idx_next]);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
            dig_en_n    <= '1;
            hex_out     <= 4'h0;
            blank       <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            shadow_reg  <= shadow_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
            dig_en_n    <= en_next;
            hex_out     <= nib_next[idx_next];
            blank       <= blank_next;
            frame_done  <= fb;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, CLK_DIV=8, DEAD=2).
// A frame-position model (position within the frame, displayed value, latest
// write) predicts every output each cycle for a BLANK_LZ=1 and a BLANK_LZ=0 instance.
module tb_seg_scan_ctrl;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_in = 16'h0;

    logic [3:0]  a_hex, b_hex;
    logic        a_blank, b_blank;
    logic [3:0]  a_en, b_en;
    logic        a_fd, b_fd;

    seg_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_we(data_we),
        .hex_out(a_hex), .blank(a_blank), .dig_en_n(a_en), .frame_done(a_fd)
    );

    seg_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD), .BLANK_LZ(0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_we(data_we),
        .hex_out(b_hex), .blank(b_blank), .dig_en_n(b_en), .frame_done(b_fd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position in frame (after the latest edge), value on display,
    // latest write and whether it is still waiting for a frame boundary.
    int          pos;
    logic [15:0] shown;
    logic [15:0] last_wr;
    bit          pend;
    bit          fd_exp;

    typedef struct {
        logic [15:0] value;
        int          wr_pos;
        logic [3:0]  exp_blank;   // bit d: digit d blanked while lit (BLANK_LZ=1)
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (frame pos %0d)", name, act, exp, pos);
        end
    endtask

    task automatic model_reset();
        pos = 0; shown = 16'h0; last_wr = 16'h0; pend = 0; fd_exp = 0;
    endtask

    task automatic compare_all();
        int          slot;
        int          off;
        bit          dead;
        logic [15:0] upper;
        int          exp_en;
        int          exp_hex;
        slot    = pos / CLK_DIV;
        off     = pos % CLK_DIV;
        dead    = (off < DEAD);
        upper   = shown >> (4 * slot);
        exp_hex = int'(upper & 16'h000F);
        exp_en  = dead ? 4'hF : int'(~(4'b0001 << slot) & 4'hF);
        check("dig_en_n", int'(a_en), exp_en);
        check("hex_out", int'(a_hex), exp_hex);
        check("blank", int'(a_blank), int'(dead || (slot > 0 && upper == 16'h0)));
        check("frame_done", int'(a_fd), int'(fd_exp));
        check("nolz_dig_en_n", int'(b_en), exp_en);
        check("nolz_hex_out", int'(b_hex), exp_hex);
        check("nolz_blank", int'(b_blank), int'(dead));
        check("nolz_frame_done", int'(b_fd), int'(fd_exp));
        check("enable_onehot", int'($countones(~a_en) <= 1), 1);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input bit we, input logic [15:0] d);
        data_we = we;
        data_in = d;
        @(posedge clk);
        if (pos == FRAME - 1) begin
            fd_exp = 1;
            if (we) shown = d;
            else if (pend) shown = last_wr;
            pend = 0;
            if (we) last_wr = d;
        end else begin
            fd_exp = 0;
            if (we) begin
                last_wr = d;
                pend = 1;
            end
        end
        pos = (pos + 1) % FRAME;
        @(negedge clk);
        data_we = 1'b0;
        compare_all();
    endtask

    task automatic skip_to(input int target);
        for (int k = 0; k < FRAME && pos != target; k++) step(0, 16'h0);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before the next edge.
    task automatic reset_now();
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int fd_cnt;
        int e0;
        vecs[0] = '{16'h12A4,  5, 4'b0000};
        vecs[1] = '{16'h0050, 12, 4'b1100};
        vecs[2] = '{16'h0000, 20, 4'b1110};
        vecs[3] = '{16'h1000, 27, 4'b0000};
        vecs[4] = '{16'h0100,  1, 4'b1000};
        vecs[5] = '{16'h000F, 30, 4'b1110};
        vecs[6] = '{16'h0A0B, 17, 4'b1000};

        // Reset state
        model_reset();
        repeat (2) begin
            @(negedge clk);
            compare_all();
        end
        #1 rst_n = 1'b1;

        // Idle scan after reset: frame_done once per 32 cycles
        fd_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(0, 16'h0);
            if (a_fd) fd_cnt++;
        end
        check("frame_done_count", fd_cnt, 2);
        $display("idle scan: %0d frame_done pulses in %0d cycles", fd_cnt, 2 * FRAME);

        // Table-driven writes: value held until the boundary, then shown with LZ blanking
        for (int v = 0; v < 7; v++) begin
            e0 = errors;
            skip_to(vecs[v].wr_pos);
            step(1, vecs[v].value);
            skip_to(0);
            for (int k = 0; k < FRAME; k++) begin
                if (pos % CLK_DIV == DEAD) begin
                    logic [15:0] tmp;
                    int sl;
                    sl  = pos / CLK_DIV;
                    tmp = vecs[v].value >> (4 * sl);
                    check("vec_hex", int'(a_hex), int'(tmp & 16'h000F));
                    check("vec_blank", int'(a_blank), int'(vecs[v].exp_blank[sl]));
                    check("vec_nolz_blank", int'(b_blank), 0);
                end
                step(0, 16'h0);
            end
            $display("vector %0d: write %04h at pos %0d, %0d new errors", v, vecs[v].value,
                     vecs[v].wr_pos, errors - e0);
        end

        // Two writes in one frame: the last one wins
        skip_to(3);
        step(1, 16'h1111);
        step(0, 16'h0);
        step(1, 16'h2222);
        skip_to(0);
        for (int k = 0; k < FRAME - 1; k++) begin
            if (pos % CLK_DIV == DEAD) check("double_write_hex", int'(a_hex), 2);
            step(0, 16'h0);
        end
        // Write on the exact boundary cycle loads straight into the display
        step(1, 16'h3333);
        check("fb_write_hex", int'(a_hex), 3);
        check("fb_write_frame_done", int'(a_fd), 1);
        for (int k = 0; k < FRAME; k++) begin
            if (pos % CLK_DIV == DEAD) check("fb_write_digit", int'(a_hex), 3);
            step(0, 16'h0);
        end
        $display("double write and boundary write sequence done");

        // Reset in slot 2 with a write still pending: all of it is lost
        skip_to(10);
        step(1, 16'h5555);
        skip_to(18);
        reset_now();
        step(0, 16'h0);
        step(0, 16'h0);
        check("rst_restart_en", int'(a_en), 4'b1110);
        check("rst_restart_hex", int'(a_hex), 0);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (pos % CLK_DIV == DEAD) check("rst_pending_lost", int'(a_hex), 0);
            step(0, 16'h0);
        end
        $display("mid-frame reset sequence done");

        // Random writes with random leading-zero counts
        for (int k = 0; k < 800; k++) begin
            logic [15:0] d;
            bit we;
            d  = 16'($urandom >> (16 + 4 * $urandom_range(0, 4)));
            we = ($urandom_range(0, 11) == 0);
            step(we, d);
        end
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
